// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the counter sequencer.
//   OP_*  : command opcodes carried on cmd_op
//   S_*   : controller state encodings
package counter_ctrl_defs;

    typedef logic [1:0] op_t;

    localparam op_t OP_LOAD   = 2'd0;
    localparam op_t OP_UP     = 2'd1;
    localparam op_t OP_DOWN   = 2'd2;
    localparam op_t OP_RUN_TO = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/counter_sequencer_if.sv
// Host command channel of the counter sequencer (valid/ready handshake).
//   cmd_valid : host -> controller, command present
//   cmd_ready : controller -> host, command accepted on valid & ready
//   cmd_op    : host -> controller, opcode (see counter_ctrl_defs)
//   cmd_arg   : host -> controller, load value / step count / target
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/counter_sequencer_step_prescaler.sv
// Step-rate prescaler: produces a tick every PRESCALE non-held cycles.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   clear : forces the divider back to zero and suppresses tick
//   hold  : freezes the divider and suppresses tick
//   tick  : combinational, high when a step is due this cycle
module step_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);
    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    assign tick = !clear && !hold && (presc == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            presc <= '0;
        else if (clear)
            presc <= '0;
        else if (!hold)
            presc <= tick ? '0 : presc + PW'(1);
    end
endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller for a loadable up/down counter.
//   clk, reset : clock, asynchronous active-high reset
//   cmd        : host command channel (slave side)
//   pause      : freezes stepping while high
//   abort      : terminates an active count
//   cnt_q      : live counter value
//   cnt_load / cnt_data / cnt_en / cnt_mode : counter control pins
//   busy       : controller not idle
//   done       : one-cycle completion pulse, aborted qualifies it
//
// Step timing: the prescaler is evaluated on every edge from the accept
// edge onward, and cnt_en registers its tick, so the first pulse of a
// command lands PRESCALE cycles after acceptance. rem counts pulses not
// yet finished; it drops at the end of each en cycle, so the controller
// leaves COUNT only after the last pulse has reached the counter.
module counter_sequencer
    import counter_ctrl_defs::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               reset,
    counter_sequencer_if.slave cmd,
    input  logic               pause,
    input  logic               abort,
    input  logic [WIDTH-1:0]   cnt_q,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_data,
    output logic               cnt_en,
    output logic               cnt_mode,
    output logic               busy,
    output logic               done,
    output logic               aborted
);
    logic [1:0]       state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] start_cnt;
    logic             start_up;
    logic             accept;
    logic             start_count;
    logic             pending;
    logic             run;
    logic             tick;

    assign cmd.cmd_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign accept        = cmd.cmd_valid && (state == S_IDLE);

    // Step count and direction as decoded at the accept edge. RUN_TO takes
    // the non-wrapping path, so the direction follows the comparison.
    always_comb begin
        start_cnt = cmd.cmd_arg;
        start_up  = (cmd.cmd_op == OP_UP);
        if (cmd.cmd_op == OP_RUN_TO) begin
            start_up  = (cmd.cmd_arg > cnt_q);
            start_cnt = start_up ? cmd.cmd_arg - cnt_q : cnt_q - cmd.cmd_arg;
        end
    end

    assign start_count = accept && (cmd.cmd_op != OP_LOAD) && (start_cnt != '0);
    // A pulse still needs scheduling if rem exceeds the one in flight.
    assign pending     = (rem != WIDTH'(cnt_en));
    // Abort clears the prescaler, which also kills a step due this cycle.
    assign run         = start_count || ((state == S_COUNT) && pending && !abort);

    step_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk   (clk),
        .reset (reset),
        .clear (!run),
        .hold  (pause),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            rem      <= '0;
            cnt_load <= 1'b0;
            cnt_data <= '0;
            cnt_en   <= 1'b0;
            cnt_mode <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            cnt_load <= 1'b0;
            cnt_data <= '0;
            cnt_en   <= tick;
            done     <= 1'b0;
            aborted  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (cmd.cmd_op == OP_LOAD) begin
                            state    <= S_LOAD;
                            cnt_load <= 1'b1;
                            cnt_data <= cmd.cmd_arg;
                        end else if (start_cnt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_COUNT;
                            rem      <= start_cnt;
                            cnt_mode <= start_up;
                        end
                    end
                end
                S_LOAD: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_COUNT: begin
                    rem <= rem - WIDTH'(cnt_en);
                    if (abort || !pending) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        aborted  <= abort;
                        cnt_mode <= 1'b0;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
